// File: rtl/chime_pkg.sv
// ============================================================================
// Module : chime_pkg
// Brief  : Shared types, BCD constants and sizing helpers for the chime block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package chime_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PIP_LO = 3'd1,
    ST_PIP_HI = 3'd2,
    ST_ALARM  = 3'd3,
    ST_SNOOZE = 3'd4
  } state_t;

  localparam logic [7:0] c_bcd_00 = 8'h00;
  localparam logic [7:0] c_bcd_59 = 8'h59;

  localparam int c_num_pips = 5;
  localparam logic [7:0] c_pip_secs [c_num_pips] = '{8'h50, 8'h52, 8'h54, 8'h56, 8'h58};

  // Width of a counter that must be able to hold max_count itself.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic logic is_pip_second(input logic [7:0] sec);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < c_num_pips; i++) begin
      if (sec == c_pip_secs[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chime_time_match.sv
// ============================================================================
// Module : chime_time_match
// Brief  : Combinational BCD decode of the time-of-day into chime/alarm hits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chime_time_match
  import chime_pkg::*;
(
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  output logic       is_pip_lo,
  output logic       is_pip_hi,
  output logic       is_alarm
);

  // Plain 8-bit equality: out-of-range BCD codes can never match.
  assign is_pip_lo = (minute == c_bcd_59) && is_pip_second(second);
  assign is_pip_hi = (minute == c_bcd_00) && (second == c_bcd_00);
  assign is_alarm  = (hour == alarm_hour) && (minute == alarm_min) && (second == c_bcd_00);

endmodule

`default_nettype wire

// File: rtl/chime_controller.sv
// ============================================================================
// Module : chime_controller
// Brief  : Hourly chime and daily alarm request generator for the Beeper.
//          Optional snooze support is built when CHIME_SNOOZE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chime_controller
  import chime_pkg::*;
#(
  parameter int PIP_CYCLES = 50000000,
  parameter int ALARM_SECS = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       chime_en,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_stop,
  input  logic       snooze,
  output logic       open512,
  output logic       open1k,
  output logic       alarm_active
);

  localparam int                    c_pip_w     = cnt_width(PIP_CYCLES);
  localparam logic [c_pip_w-1:0]    c_pip_max   = c_pip_w'(PIP_CYCLES);
  localparam logic [c_pip_w-1:0]    c_pip_one   = c_pip_w'(1);
  localparam int                    c_alarm_w   = cnt_width(ALARM_SECS);
  localparam logic [c_alarm_w-1:0]  c_alarm_max = c_alarm_w'(ALARM_SECS);
  localparam logic [c_alarm_w-1:0]  c_alarm_one = c_alarm_w'(1);

  state_t               r_state;
  logic [c_pip_w-1:0]   r_pip_cnt;
  logic [c_alarm_w-1:0] r_alarm_cnt;
  logic                 r_open512;
  logic                 r_open1k;
  logic                 r_alarm_active;

  logic                 w_is_pip_lo;
  logic                 w_is_pip_hi;
  logic                 w_is_alarm;
  logic                 w_alarm_hit;
  logic                 w_lo_hit;
  logic                 w_hi_hit;
  logic [c_alarm_w-1:0] w_alarm_next;

  chime_time_match u_time_match (
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .is_pip_lo  (w_is_pip_lo),
    .is_pip_hi  (w_is_pip_hi),
    .is_alarm   (w_is_alarm)
  );

  assign w_alarm_hit  = alarm_en & w_is_alarm;
  assign w_lo_hit     = chime_en & w_is_pip_lo;
  assign w_hi_hit     = chime_en & w_is_pip_hi;
  assign w_alarm_next = r_alarm_cnt + c_alarm_one;

`ifdef CHIME_SNOOZE_EN
  localparam int                     c_snooze_ticks = SNOOZE_MIN * 60;
  localparam int                     c_snooze_w     = cnt_width(c_snooze_ticks);
  localparam logic [c_snooze_w-1:0]  c_snooze_max   = c_snooze_w'(c_snooze_ticks);
  localparam logic [c_snooze_w-1:0]  c_snooze_one   = c_snooze_w'(1);

  logic [c_snooze_w-1:0] r_snooze_cnt;
  logic [c_snooze_w-1:0] w_snooze_next;

  assign w_snooze_next = r_snooze_cnt + c_snooze_one;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = snooze ^ (SNOOZE_MIN == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_pip_cnt      <= '0;
      r_alarm_cnt    <= '0;
      r_open512      <= 1'b0;
      r_open1k       <= 1'b0;
      r_alarm_active <= 1'b0;
`ifdef CHIME_SNOOZE_EN
      r_snooze_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (tick_1hz) begin
            if (w_alarm_hit) begin
              r_state        <= ST_ALARM;
              r_alarm_cnt    <= '0;
              r_open512      <= 1'b0;
              r_open1k       <= 1'b1;
              r_alarm_active <= 1'b1;
            end else if (w_lo_hit) begin
              r_state   <= ST_PIP_LO;
              r_pip_cnt <= c_pip_one;
              r_open512 <= 1'b1;
              r_open1k  <= 1'b0;
            end else if (w_hi_hit) begin
              r_state   <= ST_PIP_HI;
              r_pip_cnt <= c_pip_one;
              r_open512 <= 1'b0;
              r_open1k  <= 1'b1;
            end
          end
        end

        ST_PIP_LO, ST_PIP_HI: begin
          // An alarm match always pre-empts a chime pip still in progress.
          if (tick_1hz && w_alarm_hit) begin
            r_state        <= ST_ALARM;
            r_pip_cnt      <= '0;
            r_alarm_cnt    <= '0;
            r_open512      <= 1'b0;
            r_open1k       <= 1'b1;
            r_alarm_active <= 1'b1;
          end else if (r_pip_cnt == c_pip_max) begin
            r_state   <= ST_IDLE;
            r_pip_cnt <= '0;
            r_open512 <= 1'b0;
            r_open1k  <= 1'b0;
          end else begin
            r_pip_cnt <= r_pip_cnt + c_pip_one;
          end
        end

        ST_ALARM: begin
          if (alarm_stop || !alarm_en) begin
            r_state        <= ST_IDLE;
            r_alarm_cnt    <= '0;
            r_open512      <= 1'b0;
            r_open1k       <= 1'b0;
            r_alarm_active <= 1'b0;
`ifdef CHIME_SNOOZE_EN
          end else if (snooze) begin
            r_state      <= ST_SNOOZE;
            r_alarm_cnt  <= '0;
            r_snooze_cnt <= '0;
            r_open512    <= 1'b0;
            r_open1k     <= 1'b0;
`endif
          end else if (tick_1hz) begin
            if (w_alarm_next == c_alarm_max) begin
              r_state        <= ST_IDLE;
              r_alarm_cnt    <= '0;
              r_open512      <= 1'b0;
              r_open1k       <= 1'b0;
              r_alarm_active <= 1'b0;
            end else begin
              // Tone on for even elapsed seconds, off for odd ones.
              r_alarm_cnt <= w_alarm_next;
              r_open1k    <= ~w_alarm_next[0];
            end
          end
        end

`ifdef CHIME_SNOOZE_EN
        ST_SNOOZE: begin
          if (alarm_stop || !alarm_en) begin
            r_state        <= ST_IDLE;
            r_snooze_cnt   <= '0;
            r_open512      <= 1'b0;
            r_open1k       <= 1'b0;
            r_alarm_active <= 1'b0;
          end else if (tick_1hz) begin
            if (w_snooze_next == c_snooze_max) begin
              r_state      <= ST_ALARM;
              r_snooze_cnt <= '0;
              r_alarm_cnt  <= '0;
              r_open1k     <= 1'b1;
            end else begin
              r_snooze_cnt <= w_snooze_next;
            end
          end
        end
`endif

        default: begin
          r_state        <= ST_IDLE;
          r_pip_cnt      <= '0;
          r_alarm_cnt    <= '0;
          r_open512      <= 1'b0;
          r_open1k       <= 1'b0;
          r_alarm_active <= 1'b0;
        end
      endcase
    end
  end

  assign open512      = r_open512;
  assign open1k       = r_open1k;
  assign alarm_active = r_alarm_active;

endmodule

`default_nettype wire

// File: tb/tb_chime_controller.sv
// ============================================================================
// Module : tb_chime_controller
// Brief  : Directed table-driven bench for chime_controller (PIP_CYCLES=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_chime_controller;

  localparam int PIP_CYCLES = 8;
  localparam int ALARM_SECS = 6;
  localparam int SNOOZE_MIN = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [7:0] hour = 8'h00;
  logic [7:0] minute = 8'h00;
  logic [7:0] second = 8'h00;
  logic       chime_en = 1'b0;
  logic       alarm_en = 1'b0;
  logic [7:0] alarm_hour = 8'h00;
  logic [7:0] alarm_min = 8'h00;
  logic       alarm_stop = 1'b0;
  logic       snooze = 1'b0;
  logic       open512;
  logic       open1k;
  logic       alarm_active;

  int checks = 0;
  int errors = 0;

  chime_controller #(
    .PIP_CYCLES (PIP_CYCLES),
    .ALARM_SECS (ALARM_SECS),
    .SNOOZE_MIN (SNOOZE_MIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .hour         (hour),
    .minute       (minute),
    .second       (second),
    .chime_en     (chime_en),
    .alarm_en     (alarm_en),
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .alarm_stop   (alarm_stop),
    .snooze       (snooze),
    .open512      (open512),
    .open1k       (open1k),
    .alarm_active (alarm_active)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {open512, open1k, alarm_active}.
  typedef struct {
    logic [7:0] h, m, s, ah, am;
    logic       ch, ae;
    logic [2:0] win;
    logic [2:0] aft;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  function automatic vec_t mk(input int h, input int m, input int s, input logic ch,
                              input logic ae, input int ah, input int am,
                              input logic [2:0] win, input logic [2:0] aft);
    vec_t v;
    v.h = bcd(h); v.m = bcd(m); v.s = bcd(s);
    v.ah = bcd(ah); v.am = bcd(am);
    v.ch = ch; v.ae = ae; v.win = win; v.aft = aft;
    return v;
  endfunction

  // One step of the 12:59:49 .. 13:00:01 window, t = 0..12.
  function automatic vec_t chime_row(input int t, input logic ch);
    int h, m, s;
    logic [2:0] win;
    if (t < 11) begin h = 12; m = 59; s = 49 + t; end
    else begin h = 13; m = 0; s = t - 11; end
    win = 3'b000;
    if (ch && m == 59 && s >= 50 && (s % 2) == 0) win = 3'b100;
    if (ch && m == 0 && s == 0) win = 3'b010;
    return mk(h, m, s, ch, 1'b0, 0, 0, win, 3'b000);
  endfunction

  task automatic chk3(input string nm, input logic [2:0] exp);
    logic [2:0] got;
    got = {open512, open1k, alarm_active};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {open512,open1k,alarm_active}=%b expected %b", nm, got, exp);
    end
  endtask

  // One second slot of 20 clk: tick, then sample inside and after the pip window.
  task automatic run_second(input vec_t v, input string nm);
    @(negedge clk);
    hour = v.h; minute = v.m; second = v.s;
    chime_en = v.ch; alarm_en = v.ae;
    alarm_hour = v.ah; alarm_min = v.am;
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k == 0) chk3({nm, "_first"}, v.win);
      if (k == 7) chk3({nm, "_last"}, v.win);
      if (k == 8) chk3({nm, "_drop"}, v.aft);
      if (k == 17) chk3({nm, "_late"}, v.aft);
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic do_stop, input logic do_snooze);
    @(negedge clk);
    alarm_stop = do_stop;
    snooze = do_snooze;
    @(negedge clk);
    alarm_stop = 1'b0;
    snooze = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (open512 && open1k) begin
        errors++;
        $display("FAIL invariant: open512=%b open1k=%b both high at %0t", open512, open1k, $time);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Chime on, chime off, 07:30 alarm, alarm colliding with the 13:00 chime.
    for (int t = 0; t < 13; t++) vecs.push_back(chime_row(t, 1'b1));
    for (int t = 0; t < 13; t++) vecs.push_back(chime_row(t, 1'b0));
    vecs.push_back(mk(7, 29, 59, 1, 1, 7, 30, 3'b000, 3'b000));
    vecs.push_back(mk(7, 30,  0, 1, 1, 7, 30, 3'b011, 3'b011));
    vecs.push_back(mk(7, 30,  1, 1, 1, 7, 30, 3'b001, 3'b001));
    vecs.push_back(mk(7, 30,  2, 1, 1, 7, 30, 3'b011, 3'b011));
    vecs.push_back(mk(7, 30,  3, 1, 1, 7, 30, 3'b001, 3'b001));
    vecs.push_back(mk(7, 30,  4, 1, 1, 7, 30, 3'b011, 3'b011));
    vecs.push_back(mk(7, 30,  5, 1, 1, 7, 30, 3'b001, 3'b001));
    vecs.push_back(mk(7, 30,  6, 1, 1, 7, 30, 3'b000, 3'b000));
    vecs.push_back(mk(7, 30,  7, 1, 1, 7, 30, 3'b000, 3'b000));
    vecs.push_back(mk(12, 59, 58, 1, 1, 13, 0, 3'b100, 3'b000));
    vecs.push_back(mk(12, 59, 59, 1, 1, 13, 0, 3'b000, 3'b000));
    vecs.push_back(mk(13,  0,  0, 1, 1, 13, 0, 3'b011, 3'b011));
    vecs.push_back(mk(13,  0,  1, 1, 1, 13, 0, 3'b001, 3'b001));
    vecs.push_back(mk(13,  0,  2, 1, 1, 13, 0, 3'b011, 3'b011));
    vecs.push_back(mk(13,  0,  3, 1, 1, 13, 0, 3'b001, 3'b001));
    vecs.push_back(mk(13,  0,  4, 1, 1, 13, 0, 3'b011, 3'b011));
    vecs.push_back(mk(13,  0,  5, 1, 1, 13, 0, 3'b001, 3'b001));
    vecs.push_back(mk(13,  0,  6, 1, 1, 13, 0, 3'b000, 3'b000));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk3("reset", 3'b000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk3("post_reset_idle", 3'b000);

    for (int i = 0; i < vecs.size(); i++) run_second(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset in the middle of a 512 Hz pip.
    @(negedge clk);
    hour = bcd(12); minute = bcd(59); second = bcd(50);
    chime_en = 1'b1; alarm_en = 1'b0;
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    chk3("rst_pip_on", 3'b100);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk3("rst_async", 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk3("rst_after", 3'b000);
    run_second(mk(12, 59, 51, 1, 0, 0, 0, 3'b000, 3'b000), "rst_nomatch");
    run_second(mk(12, 59, 52, 1, 0, 0, 0, 3'b100, 3'b000), "rst_nextpip");

    // alarm_stop during elapsed second 2.
    run_second(mk(7, 30, 0, 1, 1, 7, 30, 3'b011, 3'b011), "stop_s0");
    run_second(mk(7, 30, 1, 1, 1, 7, 30, 3'b001, 3'b001), "stop_s1");
    run_second(mk(7, 30, 2, 1, 1, 7, 30, 3'b011, 3'b011), "stop_s2");
    pulse(1'b1, 1'b0);
    chk3("stop_edge", 3'b000);
    run_second(mk(7, 30, 3, 1, 1, 7, 30, 3'b000, 3'b000), "stop_idle");

    // Snooze at elapsed second 1, then snooze and stop together.
    run_second(mk(7, 31, 0, 1, 1, 7, 31, 3'b011, 3'b011), "snz_s0");
    run_second(mk(7, 31, 1, 1, 1, 7, 31, 3'b001, 3'b001), "snz_s1");
    pulse(1'b0, 1'b1);
    chk3("snz_edge", 3'b001);
`ifdef CHIME_SNOOZE_EN
    for (int i = 0; i < 59; i++)
      run_second(mk(7, 31, (2 + i) % 60, 1, 1, 7, 31, 3'b001, 3'b001), $sformatf("snz_wait%0d", i));
    run_second(mk(7, 32, 1, 1, 1, 7, 31, 3'b011, 3'b011), "snz_restart");
`else
    run_second(mk(7, 31, 2, 1, 1, 7, 31, 3'b011, 3'b011), "snz_ignored");
`endif
    pulse(1'b1, 1'b1);
    chk3("stop_snz_same", 3'b000);
    run_second(mk(7, 31, 3, 1, 1, 7, 31, 3'b000, 3'b000), "stop_snz_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
